decade_cascade_ctrl: RTL and testbench

Run/pause/clear sequencer for a two-digit cascade of `counter_0_to_9` decade counters (units and tens). It generates the count enables for both counters from a programmable clock prescaler and chains them with carry. It watches the counters' outputs and stops the cascade when they reach a programmed target. It sits between the user/control logic (start, stop and clear pulses) and the two counter instances, and drives their enable and reset inputs.

---
 rtl/decade_cascade_ctrl.sv | 65 ++++++
 tb/tb_decade_cascade_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decade_cascade_ctrl.sv
// decade_cascade_ctrl: run/pause/clear sequencer driving a two-digit decade counter cascade
module decade_cascade_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] target_units,
  input  logic [3:0] target_tens,
  input  logic [3:0] cnt_units,
  input  logic [3:0] cnt_tens,
  output logic       en_units,
  output logic       en_tens,
  output logic       cnt_rst,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);
  state_t state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic cnt_rst_q, busy_q, done_q;
  logic [3:0] tgt_u, tgt_t;
  logic match, run;
  assign tgt_u = target_units > 4'd9 ? 4'd9 : target_units;
  assign tgt_t = target_tens > 4'd9 ? 4'd9 : target_tens;
  assign match = {cnt_tens, cnt_units} == {tgt_t, tgt_u};
  assign run = state_q == RUN;
  assign en_units = run && presc_q == LAST && !match && !stop && !clear;
  assign en_tens = en_units && cnt_units == 4'd9;
  assign cnt_rst = cnt_rst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign state = state_q;
  // next state and prescaler; a stop freezes presc so a suppressed tick fires right after resume
  always_comb begin
    state_d = clear ? IDLE :
              (state_q == IDLE && start) ? RUN :
              (run && stop) ? PAUSE :
              (run && match) ? DONE :
              (state_q == PAUSE && start) ? RUN : state_q;
    presc_d = (clear || (state_q == IDLE && start)) ? '0 :
              (run && !stop) ? (presc_q == LAST ? '0 : presc_q + 1'b1) : presc_q;
  end
  // state, prescaler and registered status outputs; cnt_rst pulses low for one cycle after clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_rst_q <= !clear;
      busy_q    <= state_d == RUN;
      done_q    <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_decade_cascade_ctrl.sv
// tb_decade_cascade_ctrl: directed checks of the cascade sequencer with behavioural decade counters
module tb_decade_cascade_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] target_units = 4'd0, target_tens = 4'd0;
  logic [3:0] cu, ct;
  logic en_units, en_tens, cnt_rst, busy, done;
  logic [1:0] state;
  int checks = 0, failures = 0;
  int eu_cnt = 0, et_cnt = 0;

  decade_cascade_ctrl #(.TICK_DIV(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .target_units(target_units), .target_tens(target_tens),
    .cnt_units(cu), .cnt_tens(ct),
    .en_units(en_units), .en_tens(en_tens), .cnt_rst(cnt_rst),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // behavioural counter_0_to_9 pair: sync active-low reset, enable, wrap 9->0
  always @(posedge clk) begin
    if (!cnt_rst) begin
      cu <= 4'd0;
      ct <= 4'd0;
    end else begin
      if (en_units) cu <= (cu == 4'd9) ? 4'd0 : cu + 4'd1;
      if (en_tens) ct <= (ct == 4'd9) ? 4'd0 : ct + 4'd1;
    end
  end

  always @(posedge clk) begin
    if (en_units) eu_cnt <= eu_cnt + 1;
    if (en_tens) et_cnt <= et_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (cnt_rst !== 1'b0) begin failures++; $display("FAIL reset_cnt_rst got=%b exp=0", cnt_rst); end
    checks++; if (en_units !== 1'b0 || en_tens !== 1'b0) begin failures++; $display("FAIL reset_en got=%b%b exp=00", en_units, en_tens); end
    rst = 1'b1;
    step();
    checks++; if (cnt_rst !== 1'b1) begin failures++; $display("FAIL release_cnt_rst got=%b exp=1", cnt_rst); end
    checks++; if (state !== 2'd0 || {ct, cu} !== 8'h00) begin failures++; $display("FAIL release_state got=%0d cnt=%h exp=0 cnt=00", state, {ct, cu}); end
  endtask

  task automatic test_target12();
    int e0, t0, hit12, hitd;
    target_units = 4'd2; target_tens = 4'd1;
    e0 = eu_cnt; t0 = et_cnt; hit12 = -1; hitd = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || state !== 2'd1) begin failures++; $display("FAIL t12_start got busy=%b state=%0d exp busy=1 state=1", busy, state); end
    for (int i = 1; i <= 200; i++) begin
      step();
      if ({ct, cu} == 8'h12 && hit12 < 0) hit12 = i;
      if (done) begin hitd = i; break; end
    end
    checks++; if (hit12 !== 48) begin failures++; $display("FAIL t12_reach got=%0d exp=48", hit12); end
    checks++; if (hitd !== 49) begin failures++; $display("FAIL t12_done_latency got=%0d exp=49", hitd); end
    checks++; if (eu_cnt - e0 !== 12) begin failures++; $display("FAIL t12_units_pulses got=%0d exp=12", eu_cnt - e0); end
    checks++; if (et_cnt - t0 !== 1) begin failures++; $display("FAIL t12_tens_pulses got=%0d exp=1", et_cnt - t0); end
    checks++; if (busy !== 1'b0 || state !== 2'd3 || {ct, cu} !== 8'h12) begin failures++; $display("FAIL t12_final got busy=%b state=%0d cnt=%h exp 0/3/12", busy, state, {ct, cu}); end
    step();
    checks++; if ({ct, cu} !== 8'h12) begin failures++; $display("FAIL t12_no_overshoot got=%h exp=12", {ct, cu}); end
  endtask

  task automatic test_pause_resume();
    int e0, n, hitd;
    pulse_clear();
    target_units = 4'd5; target_tens = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while ({ct, cu} != 8'h03 && n < 100) begin step(); n++; end
    checks++; if (n !== 12) begin failures++; $display("FAIL pr_reach3 got=%0d exp=12", n); end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (state !== 2'd2 || busy !== 1'b0) begin failures++; $display("FAIL pr_paused got state=%0d busy=%b exp 2/0", state, busy); end
    e0 = eu_cnt;
    repeat (20) step();
    checks++; if (eu_cnt - e0 !== 0 || state !== 2'd2 || {ct, cu} !== 8'h03) begin failures++; $display("FAIL pr_hold got pulses=%0d state=%0d cnt=%h exp 0/2/03", eu_cnt - e0, state, {ct, cu}); end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while ({ct, cu} == 8'h03 && n < 20) begin step(); n++; end
    checks++; if (n !== 3 || {ct, cu} !== 8'h04) begin failures++; $display("FAIL pr_resume_tick got=%0d cnt=%h exp=3 cnt=04", n, {ct, cu}); end
    hitd = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (done) begin hitd = i; break; end
    end
    checks++; if (hitd !== 5 || {ct, cu} !== 8'h05) begin failures++; $display("FAIL pr_done got=%0d cnt=%h exp=5 cnt=05", hitd, {ct, cu}); end
  endtask

  task automatic test_target00();
    int e0;
    pulse_clear();
    target_units = 4'd0; target_tens = 4'd0;
    e0 = eu_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 2'd1 || en_units !== 1'b0) begin failures++; $display("FAIL t00_run got state=%0d en=%b exp 1/0", state, en_units); end
    step();
    checks++; if (state !== 2'd3 || done !== 1'b1 || eu_cnt - e0 !== 0) begin failures++; $display("FAIL t00_done got state=%0d done=%b pulses=%0d exp 3/1/0", state, done, eu_cnt - e0); end
  endtask

  task automatic test_clamp_lockout();
    int t0, hitd;
    pulse_clear();
    target_units = 4'd15; target_tens = 4'd0;
    t0 = et_cnt; hitd = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (done) begin hitd = i; break; end
    end
    checks++; if (hitd !== 37 || {ct, cu} !== 8'h09 || et_cnt - t0 !== 0) begin failures++; $display("FAIL clamp got=%0d cnt=%h tens=%0d exp=37 cnt=09 tens=0", hitd, {ct, cu}, et_cnt - t0); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL done_start got=%0d exp=3", state); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL done_stop got=%0d exp=3", state); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (state !== 2'd0 || cnt_rst !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL done_clear got state=%0d cnt_rst=%b done=%b exp 0/0/0", state, cnt_rst, done); end
    step();
    checks++; if (cnt_rst !== 1'b1 || {ct, cu} !== 8'h00) begin failures++; $display("FAIL clear_release got cnt_rst=%b cnt=%h exp 1/00", cnt_rst, {ct, cu}); end
  endtask

  task automatic test_simultaneous();
    int n;
    target_units = 4'd9; target_tens = 4'd9;
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL clear_start got state=%0d busy=%b exp 0/0", state, busy); end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++; if (en_units !== 1'b1) begin failures++; $display("FAIL tick_pending got=%b exp=1", en_units); end
    stop = 1'b1;
    #1;
    checks++; if (en_units !== 1'b0) begin failures++; $display("FAIL stop_suppress got=%b exp=0", en_units); end
    step();
    stop = 1'b0;
    checks++; if (state !== 2'd2 || {ct, cu} !== 8'h00) begin failures++; $display("FAIL stop_tick got state=%0d cnt=%h exp 2/00", state, {ct, cu}); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (en_units !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", en_units); end
    step();
    checks++; if ({ct, cu} !== 8'h01) begin failures++; $display("FAIL resume_count got=%h exp=01", {ct, cu}); end
    n = 0;
    while ({ct, cu} != 8'h07 && n < 100) begin step(); n++; end
    checks++; if (n !== 24) begin failures++; $display("FAIL reach7 got=%0d exp=24", n); end
    rst = 1'b0;
    step();
    checks++; if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || cnt_rst !== 1'b0 || en_units !== 1'b0 || en_tens !== 1'b0) begin failures++; $display("FAIL rst_midrun got state=%0d busy=%b done=%b cnt_rst=%b en=%b%b", state, busy, done, cnt_rst, en_units, en_tens); end
    step();
    checks++; if ({ct, cu} !== 8'h00) begin failures++; $display("FAIL rst_counters got=%h exp=00", {ct, cu}); end
    rst = 1'b1;
    step();
    checks++; if (cnt_rst !== 1'b1 || state !== 2'd0) begin failures++; $display("FAIL rst_release got cnt_rst=%b state=%0d exp 1/0", cnt_rst, state); end
  endtask

  initial begin
    test_reset();
    test_target12();
    test_pause_resume();
    test_target00();
    test_clamp_lockout();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
